// File: rtl/spi2adc.sv
`default_nettype none
// ============================================================================
// Module   : spi2adc
// Purpose  : SPI master that reads one 10-bit sample from an MCP3002 ADC for
//            each accepted start pulse, then presents the result on data_out
//            together with a single-cycle data_valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module spi2adc #(
  parameter int SCK_HALF = 25               // sysclk cycles per SCK half-period (>= 2)
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       channel,
  input  logic       ADC_SDO,
  output logic       ADC_SDI,
  output logic       ADC_CS,
  output logic       ADC_SCK,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       busy
);

  localparam int               c_DIV_W    = $clog2(SCK_HALF);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCK_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CS_SETUP = 3'd1,
    S_SHIFT    = 3'd2,
    S_CS_HOLD  = 3'd3,
    S_RECOVER  = 3'd4
  } state_t;

  state_t             r_state,  w_state_nxt;
  logic [c_DIV_W-1:0] r_div,    w_div_nxt;     // cycles spent in current half-period
  logic [4:0]         r_bitcnt, w_bitcnt_nxt;  // SCK period number, 1..16
  logic [3:0]         r_cmd,    w_cmd_nxt;     // {start, SGL, ODD, MSBF}
  logic [9:0]         r_shift,  w_shift_nxt;   // incoming sample, MSB first
  logic               r_sck,    w_sck_nxt;
  logic               r_sdi,    w_sdi_nxt;
  logic               r_cs,     w_cs_nxt;
  logic [9:0]         r_data,   w_data_nxt;
  logic               r_valid,  w_valid_nxt;
  logic               r_busy,   w_busy_nxt;
  logic               w_div_last;

  assign w_div_last = (r_div == c_DIV_LAST);

  // Next-state and next-output decode; every serial output is registered so
  // the pins never glitch.
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_bitcnt_nxt = r_bitcnt;
    w_cmd_nxt    = r_cmd;
    w_shift_nxt  = r_shift;
    w_sck_nxt    = r_sck;
    w_sdi_nxt    = r_sdi;
    w_cs_nxt     = r_cs;
    w_data_nxt   = r_data;
    w_valid_nxt  = 1'b0;
    w_busy_nxt   = r_busy;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          // Channel is captured here only; later changes cannot reach the frame.
          w_cmd_nxt    = {1'b1, 1'b1, channel, 1'b1};
          w_sdi_nxt    = w_cmd_nxt[3];
          w_cs_nxt     = 1'b0;
          w_busy_nxt   = 1'b1;
          w_div_nxt    = '0;
          w_bitcnt_nxt = '0;
          w_shift_nxt  = '0;
          w_state_nxt  = S_CS_SETUP;
        end
      end

      S_CS_SETUP: begin
        if (w_div_last) begin
          w_div_nxt    = '0;
          w_bitcnt_nxt = 5'd1;
          w_state_nxt  = S_SHIFT;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      S_SHIFT: begin
        if (!w_div_last) begin
          w_div_nxt = r_div + 1'b1;
        end else begin
          w_div_nxt = '0;
          if (!r_sck) begin
            // Rising SCK edge: edges 6..15 carry B9..B0; 1..5 and 16 are dropped.
            w_sck_nxt = 1'b1;
            if (r_bitcnt >= 5'd6 && r_bitcnt <= 5'd15)
              w_shift_nxt = {r_shift[8:0], ADC_SDO};
          end else begin
            // Falling SCK edge: start of the next low phase, the only time SDI moves.
            w_sck_nxt = 1'b0;
            if (r_bitcnt == 5'd16) begin
              w_sdi_nxt   = 1'b0;
              w_state_nxt = S_CS_HOLD;
            end else begin
              w_bitcnt_nxt = r_bitcnt + 5'd1;
              case (r_bitcnt)
                5'd1:    w_sdi_nxt = r_cmd[2];
                5'd2:    w_sdi_nxt = r_cmd[1];
                5'd3:    w_sdi_nxt = r_cmd[0];
                default: w_sdi_nxt = 1'b0;
              endcase
            end
          end
        end
      end

      S_CS_HOLD: begin
        if (w_div_last) begin
          // Whole-word update of data_out, in the same cycle CS rises.
          w_div_nxt   = '0;
          w_cs_nxt    = 1'b1;
          w_data_nxt  = r_shift;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_RECOVER;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      S_RECOVER: begin
        if (w_div_last) begin
          w_div_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame with CS released at once.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bitcnt <= '0;
      r_cmd    <= '0;
      r_shift  <= '0;
      r_sck    <= 1'b0;
      r_sdi    <= 1'b0;
      r_cs     <= 1'b1;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_cmd    <= w_cmd_nxt;
      r_shift  <= w_shift_nxt;
      r_sck    <= w_sck_nxt;
      r_sdi    <= w_sdi_nxt;
      r_cs     <= w_cs_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign ADC_SDI    = r_sdi;
  assign ADC_CS     = r_cs;
  assign ADC_SCK    = r_sck;
  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign busy       = r_busy;

endmodule
`default_nettype wire
